// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding and the default datapath width.
package arith_pkg;

  localparam int ARITH_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: diff = a - b - bin, purely combinational.
module full_subtractor (
  input  logic iA,
  input  logic iB,
  input  logic iBorrow,
  output logic oDiff,
  output logic oBorrow
);

  assign oDiff   = iA ^ iB ^ iBorrow;
  assign oBorrow = (~iA & iB) | (~(iA ^ iB) & iBorrow);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one full-subtractor cell with a registered borrow.
// Optional signed overflow flag enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic             iClk,
  input  logic             iRstn,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iBorrow,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oDiff,
  output logic             oBorrow,
  output logic             oOverflow
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state_r;
  state_t           state_next_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:1] res_r;
  logic             brw_r;
  logic             cell_d_s;
  logic             cell_b_s;
  logic             accept_s;
  logic             last_s;
  logic [WIDTH-1:0] res_shift_s;

  full_subtractor u_cell (
    .iA      (a_r[0]),
    .iB      (b_r[0]),
    .iBorrow (brw_r),
    .oDiff   (cell_d_s),
    .oBorrow (cell_b_s)
  );

  assign accept_s    = iStart & ((state_r == IDLE) | (state_r == DONE));
  assign last_s      = (state_r == RUN) & (cnt_r == LAST_BIT);
  // Bit 0 of the partial result is only ever needed on the final edge, so it is not stored.
  assign res_shift_s = {cell_d_s, res_r};

  // FSM state register
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = iStart ? RUN : IDLE;
      RUN:     state_next_s = last_s ? DONE : RUN;
      DONE:    state_next_s = iStart ? RUN : IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Operand shift registers, borrow chain and bit counter
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      a_r   <= '0;
      b_r   <= '0;
      res_r <= '0;
      brw_r <= 1'b0;
      cnt_r <= '0;
    end else if (accept_s) begin
      a_r   <= iA;
      b_r   <= iB;
      res_r <= '0;
      brw_r <= iBorrow;
      cnt_r <= '0;
    end else if (state_r == RUN) begin
      a_r   <= {1'b0, a_r[WIDTH-1:1]};
      b_r   <= {1'b0, b_r[WIDTH-1:1]};
      res_r <= res_shift_s[WIDTH-1:1];
      brw_r <= cell_b_s;
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      brw_r <= brw_r;
    end
  end

  // Registered status and result outputs; results change only on the last bit edge
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
      oDiff   <= '0;
      oBorrow <= 1'b0;
    end else begin
      oBusy <= (state_next_s == RUN);
      oDone <= last_s;
      if (last_s) begin
        oDiff   <= res_shift_s;
        oBorrow <= cell_b_s;
      end else begin
        oDiff   <= oDiff;
        oBorrow <= oBorrow;
      end
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic sign_a_r;
  logic sign_b_r;

  // Operand signs latched at accept; overflow evaluated from the final difference bit
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      sign_a_r  <= 1'b0;
      sign_b_r  <= 1'b0;
      oOverflow <= 1'b0;
    end else if (accept_s) begin
      sign_a_r  <= iA[WIDTH-1];
      sign_b_r  <= iB[WIDTH-1];
    end else if (last_s) begin
      oOverflow <= (sign_a_r ^ sign_b_r) & (cell_d_s ^ sign_a_r);
    end else begin
      oOverflow <= oOverflow;
    end
  end
`else
  assign oOverflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rstn;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;

  int           checks;
  int           failures;
  logic [W-1:0] prev_diff;
  logic         prev_borrow;
  logic         prev_ovf;

  serial_subtractor #(.WIDTH(W)) dut (
    .iClk      (clk),
    .iRstn     (rstn),
    .iStart    (start),
    .iA        (a),
    .iB        (b),
    .iBorrow   (bin),
    .oBusy     (busy),
    .oDone     (done),
    .oDiff     (diff),
    .oBorrow   (borrow),
    .oOverflow (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: unsigned subtraction in one step wider than the operands
  function automatic logic [W:0] ref_full(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    ref_full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] d);
`ifdef SERIAL_SUB_OVERFLOW_EN
    ref_ovf = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
`else
    ref_ovf = 1'b0;
`endif
  endfunction

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #23;
    checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)   begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (diff !== 8'h00)  begin failures++; $display("FAIL reset_diff got=%h exp=00", diff); end
    checks++; if (borrow !== 1'b0) begin failures++; $display("FAIL reset_borrow got=%b exp=0", borrow); end
    checks++; if (ovf !== 1'b0)    begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    @(negedge clk); rstn = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset got busy=%b done=%b exp 0/0", busy, done);
    end
    prev_diff = '0; prev_borrow = 1'b0; prev_ovf = 1'b0;
  endtask

  // One operation with full timing checks; optional iStart pulses during RUN
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input bit pulse);
    logic [W:0]   full;
    logic [W-1:0] ed;
    logic         eb, eo;
    full = ref_full(x, y, c);
    ed = full[W-1:0];
    eb = full[W];
    eo = ref_ovf(x, y, ed);
    @(negedge clk); a = x; b = y; bin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin
        failures++; $display("FAIL run_busy bit=%0d got busy=%b done=%b exp 1/0", i, busy, done);
      end
      checks++; if (diff !== prev_diff || borrow !== prev_borrow || ovf !== prev_ovf) begin
        failures++; $display("FAIL run_stable bit=%0d got %h/%b/%b exp %h/%b/%b", i, diff, borrow, ovf, prev_diff, prev_borrow, prev_ovf);
      end
      start = pulse && (i >= 2) && (i <= 4);
      a = W'($urandom); b = W'($urandom);
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin
      failures++; $display("FAIL done_cycle got busy=%b done=%b exp 0/1", busy, done);
    end
    checks++; if (diff !== ed) begin
      failures++; $display("FAIL diff a=%h b=%h bin=%b got=%h exp=%h", x, y, c, diff, ed);
    end
    checks++; if (borrow !== eb) begin
      failures++; $display("FAIL borrow a=%h b=%h bin=%b got=%b exp=%b", x, y, c, borrow, eb);
    end
    checks++; if (ovf !== eo) begin
      failures++; $display("FAIL overflow a=%h b=%h bin=%b got=%b exp=%b", x, y, c, ovf, eo);
    end
    prev_diff = ed; prev_borrow = eb; prev_ovf = eo;
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL done_pulse_width got busy=%b done=%b exp 0/0", busy, done);
    end
  endtask

  task automatic test_directed();
    run_op(8'h05, 8'h03, 1'b0, 1'b0);
    run_op(8'h03, 8'h05, 1'b0, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 1'b0);
    run_op(8'h80, 8'h01, 1'b0, 1'b0);
    run_op(8'h7F, 8'hFF, 1'b0, 1'b0);
    run_op(8'h00, 8'hFF, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), (n % 3) == 0);
    end
  endtask

  // iStart held high; each op must use operands present at its own accepting edge
  task automatic test_back_to_back();
    localparam int OPS = 4;
    logic [W-1:0] qa [0:OPS*(W+1)];
    logic [W-1:0] qb [0:OPS*(W+1)];
    logic         qc [0:OPS*(W+1)];
    logic [W:0]   full;
    int           k;
    @(negedge clk);
    qa[0] = W'($urandom); qb[0] = W'($urandom); qc[0] = 1'($urandom);
    a = qa[0]; b = qb[0]; bin = qc[0]; start = 1'b1;
    for (int c = 1; c <= OPS * (W + 1); c++) begin
      @(posedge clk);
      @(negedge clk);
      if (((c - 1) % (W + 1)) == W) begin
        k = (c - 1) - W;
        full = ref_full(qa[k], qb[k], qc[k]);
        checks++; if (done !== 1'b1) begin
          failures++; $display("FAIL b2b_done cycle=%0d got=%b exp=1", c, done);
        end
        checks++; if (diff !== full[W-1:0] || borrow !== full[W]) begin
          failures++; $display("FAIL b2b_result cycle=%0d got=%h/%b exp=%h/%b", c, diff, borrow, full[W-1:0], full[W]);
        end
        checks++; if (ovf !== ref_ovf(qa[k], qb[k], full[W-1:0])) begin
          failures++; $display("FAIL b2b_ovf cycle=%0d got=%b", c, ovf);
        end
        prev_diff = full[W-1:0]; prev_borrow = full[W]; prev_ovf = ref_ovf(qa[k], qb[k], full[W-1:0]);
      end else begin
        checks++; if (done !== 1'b0) begin
          failures++; $display("FAIL b2b_spurious_done cycle=%0d got=%b exp=0", c, done);
        end
      end
      qa[c] = W'($urandom); qb[c] = W'($urandom); qc[c] = 1'($urandom);
      a = qa[c]; b = qb[c]; bin = qc[c];
      if (c == OPS * (W + 1)) start = 1'b0;
    end
    repeat (3) begin
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL b2b_drain got busy=%b done=%b exp 0/0", busy, done);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk); a = 8'hA5; b = 8'h3C; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rstn = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || borrow !== 1'b0 || ovf !== 1'b0) begin
      failures++; $display("FAIL midrun_reset got busy=%b done=%b diff=%h borrow=%b ovf=%b exp all 0", busy, done, diff, borrow, ovf);
    end
    @(negedge clk); rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL post_reset_idle cycle=%0d got busy=%b done=%b exp 0/0", i, busy, done);
      end
    end
    prev_diff = '0; prev_borrow = 1'b0; prev_ovf = 1'b0;
    run_op(8'h80, 8'h01, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing oDiff = iA − iB − iBorrow, one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow. It is the subtraction counterpart to the accelerator's ripple-adder datapath. It serves area-constrained lanes where a parallel subtract is not worth the LUTs. A start/busy/done handshake lets a controller launch an operation and collect the result.

## Interface
- WIDTH, 32, operand and result width in bits; legal range 2..64.
- iClk  in  1  clock; all state updates on the rising edge.
- iRstn  in  1  asynchronous, active-low reset.
- iStart  in  1  start request; sampled only when idle or done.
- iA  in  WIDTH  minuend; captured on the accepting edge.
- iB  in  WIDTH  subtrahend; captured on the accepting edge.
- iBorrow  in  1  borrow-in; captured on the accepting edge.
- oBusy  out  1  high while bits are being processed.
- oDone  out  1  one-cycle pulse; marks oDiff/oBorrow/oOverflow valid.
- oDiff  out  WIDTH  difference; holds its value until the next accepted start.
- oBorrow  out  1  borrow-out from the MSB; high means unsigned iA < iB + iBorrow.
- oOverflow  out  1  signed overflow flag (see Configuration).

## Operation
- FSM states:
  - IDLE: reset state.
  - RUN: bit processing.
  - DONE: result presented for one cycle.
- IDLE or DONE with iStart=1 → RUN:
  - load the A and B shift registers and the borrow register (from iBorrow);
  - clear the bit counter;
  - clear the result shift register.
- RUN, each cycle:
  - cell inputs are a = A[0], b = B[0], bin = borrow register;
  - d = a ^ b ^ bin;
  - bout = (~a & b) | (~(a ^ b) & bin);
  - d shifts into the result MSB (result shifts right);
  - A and B shift right;
  - borrow register takes bout;
  - counter increments.
- RUN with counter = WIDTH−1 → DONE. The final bit is written on this edge.
- DONE → IDLE when iStart=0.
- iStart during RUN is ignored; no queuing and no error.
- Arithmetic is modulo 2^WIDTH. oBorrow is the final borrow register value.
- Reset value of every output:
  - oBusy = 0, oDone = 0, oBorrow = 0, oOverflow = 0;
  - oDiff = all zeros.
- Reset asserted mid-RUN aborts the operation. The FSM returns to IDLE with outputs at reset values, and no oDone is produced.

## Timing
- Call the accepting edge E0.
- oBusy is high for cycles E0..E(WIDTH−1) and low from E(WIDTH).
- oDone is high exactly in the cycle after E(WIDTH).
- Latency from the accepting edge to the oDone cycle is WIDTH cycles.
- Throughput is one operation per WIDTH+1 cycles. Back-to-back operation works by holding iStart high: a start in the DONE cycle is accepted, so oDone and the new oBusy coincide.
- oDiff, oBorrow and oOverflow update only at E(WIDTH) and are stable otherwise, including through a subsequent RUN until its last edge.
- The operand inputs need not be held after E0.

## Configuration
- SERIAL_SUB_OVERFLOW_EN defined:
  - the block latches sign(iA) and sign(iB) at E0;
  - at E(WIDTH), oOverflow = (signA ≠ signB) & (final d ≠ signA).
- SERIAL_SUB_OVERFLOW_EN undefined:
  - the overflow logic is removed;
  - oOverflow is constant 0;
  - the port remains so integration is unchanged.

## Structure
- Shared package arith_pkg holds:
  - the FSM state encoding (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2);
  - the default width constant ARITH_WIDTH = 32.
- Sub-module full_subtractor holds the single-bit cell: inputs iA, iB, iBorrow; outputs oDiff, oBorrow; purely combinational. It is instantiated once.
- Counter width is $clog2(WIDTH).

## Test plan
- WIDTH=8, reset released, A=0x05, B=0x03, Bin=0, one-cycle start → oBusy high 8 cycles; oDone in cycle 9 after start; oDiff=0x02, oBorrow=0, oOverflow=0.
- A=0x03, B=0x05, Bin=0 → oDiff=0xFE, oBorrow=1.
- A=0x00, B=0x00, Bin=1 → oDiff=0xFF, oBorrow=1.
- A=0x80, B=0x01 → oDiff=0x7F, oBorrow=0.
  - Macro defined: oOverflow=1.
  - Macro undefined: oOverflow=0.
- Start held high continuously with operands changing each op:
  - starts are accepted only at DONE cycles;
  - each oDone carries the result of the operands sampled at its own accepting edge;
  - pulses during RUN have no effect.
- iRstn pulled low at bit 4 of a RUN → all outputs 0 immediately. After release the block is in IDLE, with no oDone until a new start.
